// File: rtl/ieee754_pkg.sv
// Shared IEEE-754 single-precision constants, state encoding and packing helper
// for the post-add normalize/round stage.
package ieee754_pkg;

   typedef enum logic [1:0] {StIdle, StNorm, StRound, StOut} ieee_state_e;

   localparam int unsigned MantW     = 28;
   localparam int unsigned CarryBit  = 27;
   localparam int unsigned HiddenBit = 26;
   localparam int unsigned FracMsb   = 25;
   localparam int unsigned FracLsb   = 3;
   localparam int unsigned GuardBit  = 2;
   localparam int unsigned RoundBit  = 1;
   localparam int unsigned StickyBit = 0;
   localparam int unsigned FracW     = 23;
   localparam int unsigned ExpW      = 8;
   // Internal exponent is wider so carry/round increments past 255 stay visible.
   localparam int unsigned ExpIntW   = 10;

   localparam int unsigned ExpBias      = 127;
   localparam int unsigned ExpMaxFinite = 2 * ExpBias;

   localparam logic [ExpW-1:0]  ExpInf   = 8'hFF;
   localparam logic [FracW-1:0] FracZero = 23'h0;

   typedef struct packed {
      logic               sign;
      logic [ExpIntW-1:0] exp;
      logic [MantW-1:0]   mant;
   } raw_sum_t;

   function automatic logic [31:0] pack_sp(input logic            sign,
                                           input logic [ExpW-1:0]  exp,
                                           input logic [FracW-1:0] frac);
      return {sign, exp, frac};
   endfunction

endpackage

// File: rtl/ieee_adder_step2_if.sv
// Handshake bundle between the alignment/add stage, this normalize/round stage
// and the downstream consumer.
interface ieee_adder_step2_if;
   import ieee754_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic                in_sign;
   logic [ExpW-1:0]     in_exponent;
   logic [MantW-1:0]    in_mantissa;
   logic                out_valid;
   logic                out_ready;
   logic [31:0]         outputC;

   modport master (
      output in_valid, in_sign, in_exponent, in_mantissa, out_ready,
      input  in_ready, out_valid, outputC
   );

   modport slave (
      input  in_valid, in_sign, in_exponent, in_mantissa, out_ready,
      output in_ready, out_valid, outputC
   );

endinterface

// File: rtl/ieee_round_rne.sv
// Combinational round-to-nearest-even and packing of a normalized sum.
// Define IEEE_STEP2_ROUND_EN to round; otherwise G/R/S are dropped (truncation).
module ieee_round_rne
   import ieee754_pkg::*;
(
   input  logic               sign_i,
   input  logic [ExpIntW-1:0] exp_i,
   input  logic [HiddenBit:0] mant_i,
   input  logic               zero_sign_i,
   output logic [31:0]        result_o
);

`ifdef IEEE_STEP2_ROUND_EN
   localparam bit RoundEn = 1'b1;
`else
   localparam bit RoundEn = 1'b0;
`endif

   logic               hidden;
   logic [FracW-1:0]   frac;
   logic               guard;
   logic               rnd;
   logic               sticky;
   logic               inc;
   logic [FracW+1:0]   sum;
   logic [ExpIntW-1:0] exp_fin;
   logic [FracW-1:0]   frac_fin;

   assign hidden = mant_i[HiddenBit];
   assign frac   = mant_i[FracMsb:FracLsb];
   assign guard  = mant_i[GuardBit];
   assign rnd    = mant_i[RoundBit];
   assign sticky = mant_i[StickyBit];
   assign inc    = RoundEn & guard & (rnd | sticky | frac[0]);
   assign sum    = {1'b0, hidden, frac} + {{(FracW + 1){1'b0}}, inc};

   always_comb begin
      exp_fin  = hidden ? exp_i : '0;
      frac_fin = sum[FracW-1:0];
      if (sum[FracW+1]) begin
         // Rounding carried past the hidden bit: renormalize in place.
         exp_fin  = exp_fin + 10'd1;
         frac_fin = sum[FracW:1];
      end else if (!hidden && sum[FracW]) begin
         exp_fin = 10'd1;
      end

      if (mant_i == '0) begin
         result_o = pack_sp(zero_sign_i, '0, FracZero);
      end else if (exp_fin > ExpIntW'(ExpMaxFinite)) begin
         result_o = pack_sp(sign_i, ExpInf, FracZero);
      end else begin
         result_o = pack_sp(sign_i, exp_fin[ExpW-1:0], frac_fin);
      end
   end

endmodule

// File: rtl/ieee_adder_step2.sv
// Normalize/round stage of a single-precision adder: one-bit-per-cycle
// normalization, then rounding (RNE with IEEE_STEP2_ROUND_EN, else truncation).
module ieee_adder_step2
   import ieee754_pkg::*;
#(
   parameter logic ZERO_SIGN = 1'b0
) (
   input  logic               clock_in,
   input  logic               reset_in,
   ieee_adder_step2_if.slave  bus_io
);

   ieee_state_e        state_q;
   raw_sum_t           raw_q;
   logic               in_ready_q;
   logic               out_valid_q;
   logic [31:0]        result_q;

   logic [MantW-1:0]   mant_d;
   logic [ExpIntW-1:0] exp_d;
   logic               norm_done;
   logic [31:0]        round_result;

   always_comb begin
      mant_d    = raw_q.mant;
      exp_d     = raw_q.exp;
      norm_done = 1'b1;
      if (raw_q.mant[CarryBit]) begin
         // Bit shifted out folds into sticky so no rounding information is lost.
         mant_d = {1'b0, raw_q.mant[MantW-1:2], raw_q.mant[1] | raw_q.mant[0]};
         exp_d  = raw_q.exp + 10'd1;
      end else if (!raw_q.mant[HiddenBit] && (raw_q.mant != '0) && (raw_q.exp > 10'd1)) begin
         mant_d    = {raw_q.mant[MantW-2:0], 1'b0};
         exp_d     = raw_q.exp - 10'd1;
         norm_done = 1'b0;
      end
   end

   ieee_round_rne u_round (
      .sign_i      (raw_q.sign),
      .exp_i       (raw_q.exp),
      .mant_i      (raw_q.mant[HiddenBit:0]),
      .zero_sign_i (ZERO_SIGN),
      .result_o    (round_result)
   );

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         state_q     <= StIdle;
         raw_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         result_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus_io.in_valid) begin
                  raw_q.sign <= bus_io.in_sign;
                  raw_q.exp  <= {{(ExpIntW - ExpW){1'b0}}, bus_io.in_exponent};
                  raw_q.mant <= bus_io.in_mantissa;
                  in_ready_q <= 1'b0;
                  state_q    <= StNorm;
               end
            end
            StNorm: begin
               raw_q.mant <= mant_d;
               raw_q.exp  <= exp_d;
               if (norm_done) begin
                  state_q <= StRound;
               end
            end
            StRound: begin
               result_q    <= round_result;
               out_valid_q <= 1'b1;
               state_q     <= StOut;
            end
            StOut: begin
               // in_ready rises only on the next edge, so no same-cycle accept.
               if (bus_io.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus_io.in_ready  = in_ready_q;
   assign bus_io.out_valid = out_valid_q;
   assign bus_io.outputC   = result_q;

endmodule

// File: tb/tb_ieee_adder_step2.sv
// Scoreboard bench for ieee_adder_step2: directed corner vectors plus random sums
// checked against an integer-arithmetic reference of normalize-then-round.
module tb_ieee_adder_step2;

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ieee_adder_step2_if bus ();

   ieee_adder_step2 #(.ZERO_SIGN(1'b0)) dut (
      .clock_in (clk),
      .reset_in (rst),
      .bus_io   (bus)
   );

`ifdef IEEE_STEP2_ROUND_EN
   localparam bit RndEn = 1'b1;
   localparam logic [31:0] ExpOddTie = 32'h3F800002;
`else
   localparam bit RndEn = 1'b0;
   localparam logic [31:0] ExpOddTie = 32'h3F800001;
`endif

   exp_t sb_q[$];
   int   n_pass  = 0;
   int   n_total = 0;
   int   cyc     = 0;
   bit   hold_low = 1'b0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
   endtask

   task automatic fail_now(input string name);
      n_total++;
      $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
   endtask

   // Value view: mantissa is an integer M with value M * 2^(exp-127-26).
   function automatic void model(input logic s, input int e_in, input logic [27:0] m_in,
                                 output logic [31:0] r, output int lat);
      logic [31:0] m;
      logic [31:0] q;
      logic [31:0] rem;
      logic [31:0] fld;
      int          e;
      m   = {4'h0, m_in};
      e   = e_in;
      lat = 2;
      if (m == 0) begin
         r = 32'h0;
         return;
      end
      if (m >= 32'h0800_0000) begin
         m = (m >> 1) | (m & 32'h1);
         e = e + 1;
      end else begin
         while (m < 32'h0400_0000 && e > 1) begin
            m   = m * 2;
            e   = e - 1;
            lat = lat + 1;
         end
      end
      q   = m >> 3;
      rem = m & 32'h7;
      if (RndEn && (rem > 4 || (rem == 4 && q[0]))) q = q + 1;
      if (q >= 32'h0100_0000) begin
         q = q >> 1;
         e = e + 1;
      end
      fld = (q >= 32'h0080_0000) ? 32'(e) : 32'h0;
      if (fld >= 255) r = {s, 8'hFF, 23'h0};
      else            r = {s, fld[7:0], q[22:0]};
   endfunction

   task automatic send(input logic s, input logic [7:0] e, input logic [27:0] m,
                       input logic [31:0] res, input int lat);
      int waited = 0;
      @(negedge clk);
      bus.in_valid    = 1'b1;
      bus.in_sign     = s;
      bus.in_exponent = e;
      bus.in_mantissa = m;
      while (!bus.in_ready && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) begin
         fail_now("accept_timeout");
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      sb_q.push_back('{res: res, lat: lat, acc: cyc});
      bus.in_valid = 1'b0;
   endtask

   task automatic send_rand();
      logic        s;
      logic [7:0]  e;
      logic [27:0] m;
      logic [31:0] r;
      int          lat;
      s = 1'($urandom);
      e = 8'($urandom_range(1, 255));
      case ($urandom_range(0, 3))
         0:       m = 28'($urandom);
         1:       m = 28'($urandom) >> $urandom_range(0, 27);
         2:       m = {2'b01, 23'($urandom), 3'($urandom)};
         default: m = {1'b1, 27'($urandom)};
      endcase
      model(s, int'(e), m, r, lat);
      send(s, e, m, r, lat);
   endtask

   task automatic wait_idle();
      int waited = 0;
      while ((sb_q.size() != 0 || bus.out_valid) && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      if (sb_q.size() != 0 || bus.out_valid) fail_now("drain_timeout");
   endtask

   // Output monitor: pops one expectation per presented result, then checks hold.
   initial begin
      logic [31:0] held;
      bit          seen;
      exp_t        ex;
      held = '0;
      seen = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            seen = 1'b0;
         end else if (bus.out_valid) begin
            if (!seen) begin
               seen = 1'b1;
               held = bus.outputC;
               check("sb_depth", 32'(sb_q.size()), 32'd1);
               if (sb_q.size() != 0) begin
                  ex = sb_q.pop_front();
                  check("result", bus.outputC, ex.res);
                  check("latency", 32'(cyc - ex.acc), 32'(ex.lat));
               end
            end else begin
               check("hold_stable", bus.outputC, held);
            end
            check("in_ready_in_out", 32'(bus.in_ready), 32'd0);
         end else begin
            seen = 1'b0;
         end
      end
   end

   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(negedge clk);
         bus.out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] r;
      int          lat;
      int          waited;
      bus.in_valid    = 1'b0;
      bus.in_sign     = 1'b0;
      bus.in_exponent = '0;
      bus.in_mantissa = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_outputC", bus.outputC, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

      send(1'b0, 8'd127, 28'h8000000, 32'h40000000, 2);
      send(1'b0, 8'd127, 28'h2000000, 32'h3F000000, 3);
      send(1'b0, 8'd127, 28'h0000000, 32'h00000000, 2);
      send(1'b0, 8'd127, 28'h4000004, 32'h3F800000, 2);
      send(1'b0, 8'd127, 28'h400000C, ExpOddTie, 2);
      send(1'b0, 8'd254, 28'h8000000, 32'h7F800000, 2);
      send(1'b1, 8'd127, 28'h8000000, 32'hC0000000, 2);
      send(1'b0, 8'd1,   28'h0000100, 32'h00000020, 2);

      // Back-pressure: hold out_ready low for 5 cycles after the result appears.
      wait_idle();
      hold_low = 1'b1;
      send(1'b0, 8'd128, 28'h6000000, 32'h40400000, 2);
      waited = 0;
      while (!bus.out_valid && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.out_valid) fail_now("stall_wait");
      repeat (5) @(negedge clk);
      hold_low = 1'b0;
      send(1'b0, 8'd127, 28'h8000000, 32'h40000000, 2);

      for (int i = 0; i < 150; i++) send_rand();
      wait_idle();

      // Reset while deep in normalization (26 left shifts pending).
      send(1'b0, 8'd127, 28'h8000000, 32'h40000000, 2);
      wait_idle();
      model(1'b0, 127, 28'h0000001, r, lat);
      send(1'b0, 8'd127, 28'h0000001, r, lat);
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midnorm_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midnorm_rst_outputC", bus.outputC, 32'h0);
      @(negedge clk);
      sb_q.delete();
      rst = 1'b0;
      #1;
      check("midnorm_post_in_ready", 32'(bus.in_ready), 32'd1);
      check("midnorm_post_out_valid", 32'(bus.out_valid), 32'd0);
      send(1'b0, 8'd127, 28'h2000000, 32'h3F000000, 3);
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ieee_adder_step2.md
IEEE_ADDER_STEP2 -- requirements
Module: ieee_adder_step2

Interface
REQ-001 SHALL have parameter ZERO_SIGN, default 1'b0, meaning the sign bit placed on exact-zero results.
REQ-002 SHALL have port clock_in  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_in  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  upstream sum valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a sum.
REQ-006 SHALL have port in_sign  input  1  sign of the raw sum from the alignment/add stage.
REQ-007 SHALL have port in_exponent  input  8  biased exponent of the raw sum.
REQ-008 SHALL have port in_mantissa  input  28  raw mantissa: [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky.
REQ-009 SHALL have port out_valid  output  1  outputC holds a finished result.
REQ-010 SHALL have port out_ready  input  1  downstream consumes the result.
REQ-011 SHALL have port outputC  output  32  packed IEEE-754 single-precision result.

Function
REQ-012 SHALL implement FSM states IDLE, NORM, ROUND, OUT.
REQ-013 SHALL drive in_ready=1 only in IDLE, and out_valid=1 only in OUT.
REQ-014 SHALL, in IDLE on in_valid=1, capture the sign, exponent and mantissa and go to NORM.
REQ-015 SHALL, in NORM with carry=1, shift the mantissa right 1, OR the bit shifted out into sticky, add 1 to the exponent and go to ROUND.
REQ-016 SHALL, in NORM with carry=0, hidden=0, a nonzero mantissa and exponent>1, shift the mantissa left 1 and subtract 1 from the exponent, staying in NORM (one bit per cycle).
REQ-017 SHALL, in NORM, go to ROUND when hidden=1, when the mantissa is zero, or when exponent<=1 with hidden=0 (denormal result, exponent field 0).
REQ-018 SHALL, in ROUND, round to nearest even: increment the fraction when G & (R | S | frac LSB).
REQ-019 SHALL, when rounding overflows the hidden bit, renormalize and add 1 to the exponent in the same cycle.
REQ-020 SHALL produce infinity {sign, 8'hFF, 23'h0} when the final exponent is >=255.
REQ-021 SHALL produce {ZERO_SIGN, 31'h0} for a zero mantissa.
REQ-022 SHALL register outputC in ROUND, go to OUT, and hold outputC stable while out_valid=1 and out_ready=0.
REQ-023 SHALL return from OUT to IDLE on out_ready=1; no new input is accepted in that same cycle.
REQ-024 SHALL have a minimum latency of 2 edges after the accept edge; each left shift adds 1 edge.

Reset
REQ-025 SHALL, while reset_in=1, force state IDLE, out_valid=0, outputC=32'h0 and clear all captured registers, independent of clock_in, including in the middle of NORM or ROUND.
REQ-026 SHALL present in_ready=1 after reset.

Configuration
REQ-027 SHALL, with IEEE_STEP2_ROUND_EN defined, round per REQ-018/019.
REQ-028 SHALL, without IEEE_STEP2_ROUND_EN, truncate (ignore G/R/S) and still pass through ROUND, keeping the same latency.

Structure
REQ-029 SHALL take the state encoding, mantissa bit-field positions, exponent bias 127, and the 8'hFF/zero constants from shared package ieee754_pkg.
REQ-030 SHALL place the rounding logic in a combinational sub-module ieee_round_rne, instantiated once.

Verification
REQ-031 SHALL cover: exp=127, mantissa=28'h8000000 (carry) -> outputC=32'h40000000, out_valid 2 edges after accept.
REQ-032 SHALL cover: exp=127, mantissa=28'h2000000 -> 32'h3F000000 after 3 edges; mantissa=0 -> 32'h00000000.
REQ-033 SHALL cover: exp=127, mantissa=28'h4000004 -> 32'h3F800000 (tie to even); 28'h400000C -> 32'h3F800002 with IEEE_STEP2_ROUND_EN, 32'h3F800001 without.
REQ-034 SHALL cover: exp=254, mantissa=28'h8000000 -> 32'h7F800000.
REQ-035 SHALL cover: out_ready held 0 for 5 cycles -> outputC stable and in_ready=0 throughout; accept resumes after the release.
REQ-036 SHALL cover: reset_in pulsed mid-NORM -> out_valid=0 and outputC=0 immediately, in_ready=1 after release.
